alp_qshift_seq: RTL and testbench
=================================

Name: alp_qshift_seq

Overview:
- Q-register shift sequencer and end-of-chain shift-linkage terminator for a cascade of DC608 ALP slices.
- Drives the Q-mux select, Q-register enable and shift-direction enables of all slices to perform an N-step left or right shift of the full Q word.
- Owns the two open ends of the Q SIO chain: the l0 pin of the least-significant slice and the l3 pin of the most-significant slice.
- Each step, it supplies the fill bit into the vacated end and captures the bit shifted out of the other end.

Parameters:
- CNT_W, 5, width of the step count; maximum shift is 2^CNT_W-1 steps.

Ports:
- qdck_l, in, 1, clock; all state updates on the falling edge, the same edge that loads the ALP Q register.
- reset_h, in, 1, synchronous active-high reset.
- start_h, in, 1, request a shift sequence; sampled only in IDLE.
- dir_h, in, 1, shift direction: 0 = left (toward MSB), 1 = right.
- mode_h, in, 2, fill mode: 00 zero, 01 one, 10 rotate, 11 link.
- count_h, in, CNT_W, number of shift steps.
- link_in_h, in, 1, initial link bit, loaded at start.
- abort_h, in, 1, terminate sequence.
- busy_h, out, 1, sequence in progress.
- done_h, out, 1, one-cycle completion pulse.
- link_h, out, 1, link flop: last bit shifted out.
- qmux_onehot_h, out, 4, to all slices; uses the ALP_QMUX_* encodings.
- qreg_en_h, out, 1, Q register enable, to all slices.
- qshl_en_h, out, 1, to all slices.
- qshr_en_h, out, 1, to all slices.
- lsb_sio_oe_h, out, 1, drive enable for the LSB-slice l0 line.
- lsb_sio_out_h, out, 1, value driven on the LSB-slice l0 line.
- lsb_sio_in_h, in, 1, LSB-slice l0 line.
- msb_sio_oe_h, out, 1, drive enable for the MSB-slice l3 line.
- msb_sio_out_h, out, 1, value driven on the MSB-slice l3 line.
- msb_sio_in_h, in, 1, MSB-slice l3 line.

Behaviour:
- One clock (qdck_l). Reset is synchronous and active-high (reset_h). Reset has priority over every other input, including mid-sequence.
- Reset values:
  - state = IDLE; step counter = 0; link = 0; latched dir and mode = 0.
  - All outputs 0, except qmux_onehot_h = ALP_QMUX_NONE.
- States: IDLE, SHIFT, DONE. Control outputs are decoded from the registered state and latched fields (Moore), apart from the combinational fill path and the abort gating described below.
- IDLE:
  - start_h=1 with count_h!=0: latch dir, mode and count; load link from link_in_h; go to SHIFT.
  - start_h=1 with count_h=0: load link, go to DONE; no shift step is performed.
- SHIFT:
  - busy_h=1 and qreg_en_h=1 in every SHIFT cycle.
  - Left: qmux=ALP_QMUX_SHL, qshl_en_h=1. The controller drives lsb_sio_oe_h=1 with the fill bit; the shifted-out bit is msb_sio_in_h; msb_sio_oe_h=0.
  - Right: qmux=ALP_QMUX_SHR, qshr_en_h=1. The controller drives msb_sio_oe_h=1 with the fill bit; the shifted-out bit is lsb_sio_in_h; lsb_sio_oe_h=0.
  - Fill bit by mode:
    - zero: fill = 0.
    - one: fill = 1.
    - rotate: fill = the shifted-out bit from the same cycle (combinational from the input pin).
    - link: fill = the link flop.
  - Each falling edge: link takes the shifted-out bit and the counter decrements.
  - When the counter reaches 1, the next edge moves to DONE. Exactly count steps are performed.
- DONE: done_h=1 and busy_h=0 for one cycle, then IDLE unconditionally. start_h is ignored in DONE.
- start_h is ignored while in SHIFT; the latched fields are unaffected.
- abort_h=1 in SHIFT:
  - qreg_en_h is forced to 0 in that cycle, so no step occurs and link is held.
  - Next state is IDLE with no done pulse.
  - abort_h is ignored in IDLE and DONE.
- Outside SHIFT:
  - qreg_en, qshl_en, qshr_en and both oe outputs = 0.
  - qmux = ALP_QMUX_NONE.
  - sio_out values = 0.
- Never assert both qshl_en_h and qshr_en_h, and never assert both oe outputs.

Test Plan:
- Reset mid-sequence: left, zero fill, count 5; reset_h after 2 steps -> the next cycle shows all outputs at reset values, link_h=0, and no done_h ever pulses.
- Left zero fill, count 3 -> exactly 3 cycles with busy=1, qreg_en=1, qmux=SHL, qshl_en=1, lsb_oe=1 and lsb_out=0; done_h pulses in cycle 4; link_h = msb_sio_in_h sampled at step 3.
- Right rotate, count 1, lsb_sio_in_h=1 -> msb_oe=1 and msb_out=1 in the same cycle; link_h=1 afterwards; done next cycle.
- Link mode: link_in_h=1, left, count 2, msb_sio_in_h=0 then 1 -> lsb_out = 1 then 0; final link_h=1.
- count_h=0 -> busy never asserts, qreg_en stays 0, done_h pulses the cycle after start.
- Second start_h at step 2 of a 4-step sequence -> ignored; still 4 steps. Separately, abort_h in step 2 -> qreg_en_h=0 that cycle, IDLE next cycle, no done_h.

Source files
------------

// File: rtl/alp_qshift_seq.sv
// Q-register shift sequencer and SIO end-of-chain terminator for a cascade of ALP slices.
// State advances on the falling edge of qdck_l, the edge that loads the slice Q registers.
module alp_qshift_seq #(
  parameter int CNT_W = 5
) (
  input  logic             qdck_l,
  input  logic             reset_h,
  input  logic             start_h,
  input  logic             dir_h,
  input  logic [1:0]       mode_h,
  input  logic [CNT_W-1:0] count_h,
  input  logic             link_in_h,
  input  logic             abort_h,
  output logic             busy_h,
  output logic             done_h,
  output logic             link_h,
  output logic [3:0]       qmux_onehot_h,
  output logic             qreg_en_h,
  output logic             qshl_en_h,
  output logic             qshr_en_h,
  output logic             lsb_sio_oe_h,
  output logic             lsb_sio_out_h,
  input  logic             lsb_sio_in_h,
  output logic             msb_sio_oe_h,
  output logic             msb_sio_out_h,
  input  logic             msb_sio_in_h
);

  localparam logic [3:0] ALP_QMUX_NONE = 4'b0001;
  localparam logic [3:0] ALP_QMUX_SHL  = 4'b0010;
  localparam logic [3:0] ALP_QMUX_SHR  = 4'b0100;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_ONE    = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_LINK   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             link_r;
  logic             dir_r;
  logic [1:0]       mode_r;

  logic             in_shift_s;
  logic             shout_s;
  logic             fill_s;
  logic             step_s;

  // Shifted-out bit, fill selection and step qualification
  always_comb begin
    in_shift_s = (state_r == ST_SHIFT);
    shout_s    = dir_r ? lsb_sio_in_h : msb_sio_in_h;
    step_s     = in_shift_s & ~abort_h;
    case (mode_r)
      MODE_ZERO:   fill_s = 1'b0;
      MODE_ONE:    fill_s = 1'b1;
      MODE_ROTATE: fill_s = shout_s;
      MODE_LINK:   fill_s = link_r;
      default:     fill_s = 1'b0;
    endcase
  end

  // Slice control decode; only the vacated end of the chain is driven
  always_comb begin
    busy_h        = in_shift_s;
    done_h        = (state_r == ST_DONE);
    link_h        = link_r;
    qreg_en_h     = step_s;
    qmux_onehot_h = ALP_QMUX_NONE;
    qshl_en_h     = 1'b0;
    qshr_en_h     = 1'b0;
    lsb_sio_oe_h  = 1'b0;
    lsb_sio_out_h = 1'b0;
    msb_sio_oe_h  = 1'b0;
    msb_sio_out_h = 1'b0;
    if (in_shift_s) begin
      if (dir_r) begin
        qmux_onehot_h = ALP_QMUX_SHR;
        qshr_en_h     = 1'b1;
        msb_sio_oe_h  = 1'b1;
        msb_sio_out_h = fill_s;
      end else begin
        qmux_onehot_h = ALP_QMUX_SHL;
        qshl_en_h     = 1'b1;
        lsb_sio_oe_h  = 1'b1;
        lsb_sio_out_h = fill_s;
      end
    end else begin
      qmux_onehot_h = ALP_QMUX_NONE;
    end
  end

  // Sequencer state, step counter, latched fields and link flop
  always_ff @(negedge qdck_l) begin
    if (reset_h) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      link_r  <= 1'b0;
      dir_r   <= 1'b0;
      mode_r  <= MODE_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_h) begin
            link_r <= link_in_h;
            if (count_h != CNT_ZERO) begin
              dir_r   <= dir_h;
              mode_r  <= mode_h;
              cnt_r   <= count_h;
              state_r <= ST_SHIFT;
            end else begin
              state_r <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // An aborted cycle performs no step, so link and count hold
          if (abort_h) begin
            state_r <= ST_IDLE;
          end else begin
            link_r <= shout_s;
            cnt_r  <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_SHIFT;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alp_qshift_seq.sv
// Directed table-driven bench for alp_qshift_seq: one vector per falling-edge cycle,
// outputs compared mid-cycle against hand-computed values.
module tb_alp_qshift_seq;

  localparam int CNT_W = 5;
  localparam logic [3:0] QM_NONE = 4'b0001;
  localparam logic [3:0] QM_SHL  = 4'b0010;
  localparam logic [3:0] QM_SHR  = 4'b0100;
  localparam int NV = 31;

  logic             qdck_l;
  logic             reset_h;
  logic             start_h;
  logic             dir_h;
  logic [1:0]       mode_h;
  logic [CNT_W-1:0] count_h;
  logic             link_in_h;
  logic             abort_h;
  logic             busy_h;
  logic             done_h;
  logic             link_h;
  logic [3:0]       qmux_onehot_h;
  logic             qreg_en_h;
  logic             qshl_en_h;
  logic             qshr_en_h;
  logic             lsb_sio_oe_h;
  logic             lsb_sio_out_h;
  logic             lsb_sio_in_h;
  logic             msb_sio_oe_h;
  logic             msb_sio_out_h;
  logic             msb_sio_in_h;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             rst;
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic             link_in;
    logic             abort;
    logic             lsb_in;
    logic             msb_in;
    logic [13:0]      exp;
  } vec_t;

  vec_t tbl [NV];

  alp_qshift_seq #(.CNT_W(CNT_W)) dut (
    .qdck_l        (qdck_l),
    .reset_h       (reset_h),
    .start_h       (start_h),
    .dir_h         (dir_h),
    .mode_h        (mode_h),
    .count_h       (count_h),
    .link_in_h     (link_in_h),
    .abort_h       (abort_h),
    .busy_h        (busy_h),
    .done_h        (done_h),
    .link_h        (link_h),
    .qmux_onehot_h (qmux_onehot_h),
    .qreg_en_h     (qreg_en_h),
    .qshl_en_h     (qshl_en_h),
    .qshr_en_h     (qshr_en_h),
    .lsb_sio_oe_h  (lsb_sio_oe_h),
    .lsb_sio_out_h (lsb_sio_out_h),
    .lsb_sio_in_h  (lsb_sio_in_h),
    .msb_sio_oe_h  (msb_sio_oe_h),
    .msb_sio_out_h (msb_sio_out_h),
    .msb_sio_in_h  (msb_sio_in_h)
  );

  initial qdck_l = 1'b1;
  always #5 qdck_l = ~qdck_l;

  // Packed output word: {busy, done, link, qmux[3:0], qreg_en, shl, shr, lsb_oe, lsb_out, msb_oe, msb_out}
  function automatic logic [13:0] e_idle(input logic l);
    return {1'b0, 1'b0, l, QM_NONE, 7'b0000000};
  endfunction

  function automatic logic [13:0] e_done(input logic l);
    return {1'b0, 1'b1, l, QM_NONE, 7'b0000000};
  endfunction

  function automatic logic [13:0] e_left(input logic l, input logic f, input logic qen);
    return {1'b1, 1'b0, l, QM_SHL, qen, 1'b1, 1'b0, 1'b1, f, 1'b0, 1'b0};
  endfunction

  function automatic logic [13:0] e_right(input logic l, input logic f, input logic qen);
    return {1'b1, 1'b0, l, QM_SHR, qen, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, f};
  endfunction

  function automatic vec_t mk(input logic rst, input logic start, input logic dir,
                              input logic [1:0] mode, input logic [CNT_W-1:0] count,
                              input logic link_in, input logic abort, input logic lsb_in,
                              input logic msb_in, input logic [13:0] exp);
    vec_t v;
    v.rst = rst; v.start = start; v.dir = dir; v.mode = mode; v.count = count;
    v.link_in = link_in; v.abort = abort; v.lsb_in = lsb_in; v.msb_in = msb_in;
    v.exp = exp;
    return v;
  endfunction

  // Apply one vector, compare outputs mid-cycle, then advance through the falling edge
  task automatic cycle(input vec_t v, input string tag, input int idx);
    logic [13:0] act;
    reset_h = v.rst; start_h = v.start; dir_h = v.dir; mode_h = v.mode;
    count_h = v.count; link_in_h = v.link_in; abort_h = v.abort;
    lsb_sio_in_h = v.lsb_in; msb_sio_in_h = v.msb_in;
    #1;
    act = {busy_h, done_h, link_h, qmux_onehot_h, qreg_en_h, qshl_en_h, qshr_en_h,
           lsb_sio_oe_h, lsb_sio_out_h, msb_sio_oe_h, msb_sio_out_h};
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b (busy,done,link,qmux,qen,shl,shr,loe,lout,moe,mout)",
               tag, idx, act, v.exp);
    end
    @(negedge qdck_l);
    #2;
  endtask

  initial begin
    // left zero, count 3; msb_in 1,0,1
    tbl[0]  = mk(0, 1, 0, 2'b00, 5'd3, 0, 0, 0, 0, e_idle(0));
    tbl[1]  = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 1, e_left(0, 0, 1));
    tbl[2]  = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_left(1, 0, 1));
    tbl[3]  = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 1, e_left(0, 0, 1));
    tbl[4]  = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_done(1));
    tbl[5]  = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_idle(1));
    // right rotate, count 1, lsb_in 1
    tbl[6]  = mk(0, 1, 1, 2'b10, 5'd1, 0, 0, 0, 0, e_idle(1));
    tbl[7]  = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 1, 0, e_right(0, 1, 1));
    tbl[8]  = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_done(1));
    tbl[9]  = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_idle(1));
    // link mode, link_in 1, left, count 2; msb_in 0 then 1 (lsb_in held high as a distractor)
    tbl[10] = mk(0, 1, 0, 2'b11, 5'd2, 1, 0, 0, 0, e_idle(1));
    tbl[11] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 1, 0, e_left(1, 1, 1));
    tbl[12] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 1, 1, e_left(0, 0, 1));
    tbl[13] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_done(1));
    // count 0: straight to DONE; start in DONE ignored
    tbl[14] = mk(0, 1, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_idle(1));
    tbl[15] = mk(0, 1, 0, 2'b00, 5'd3, 1, 0, 0, 0, e_done(0));
    tbl[16] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_idle(0));
    // right one-fill, count 4; second start at step 2 ignored; lsb_in 1,1,0,1
    tbl[17] = mk(0, 1, 1, 2'b01, 5'd4, 0, 0, 0, 0, e_idle(0));
    tbl[18] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 1, 0, e_right(0, 1, 1));
    tbl[19] = mk(0, 1, 0, 2'b00, 5'd1, 0, 0, 1, 0, e_right(1, 1, 1));
    tbl[20] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_right(1, 1, 1));
    tbl[21] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 1, 0, e_right(0, 1, 1));
    tbl[22] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_done(1));
    tbl[23] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_idle(1));
    // left rotate, count 2; msb_in 1 then 0
    tbl[24] = mk(0, 1, 0, 2'b10, 5'd2, 0, 0, 0, 0, e_idle(1));
    tbl[25] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 1, e_left(0, 1, 1));
    tbl[26] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 1, 0, e_left(1, 0, 1));
    tbl[27] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_done(0));
    // right zero-fill, count 1, link_in 1, lsb_in 1
    tbl[28] = mk(0, 1, 1, 2'b00, 5'd1, 1, 0, 0, 0, e_idle(0));
    tbl[29] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 1, 0, e_right(1, 0, 1));
    tbl[30] = mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_done(1));

    reset_h = 1'b1; start_h = 1'b0; dir_h = 1'b0; mode_h = 2'b00; count_h = 5'd0;
    link_in_h = 1'b0; abort_h = 1'b0; lsb_sio_in_h = 1'b0; msb_sio_in_h = 1'b0;
    repeat (2) @(negedge qdck_l);
    #2;

    cycle(mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_idle(0)), "reset_state", 0);

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i], "table", i);
    end
    cycle(mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_idle(1)), "table_tail", 0);

    // Abort at step 2 of a left one-fill, count 4; abort in IDLE is ignored on entry
    cycle(mk(0, 1, 0, 2'b01, 5'd4, 1, 1, 0, 0, e_idle(1)), "abort", 0);
    cycle(mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, e_left(1, 1, 1)), "abort", 1);
    cycle(mk(0, 0, 0, 2'b00, 5'd0, 0, 1, 0, 1, e_left(0, 1, 0)), "abort", 2);
    for (int k = 0; k < 3; k++) begin
      cycle(mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 1, e_idle(0)), "abort_idle", k);
    end

    // Reset after two steps of a left zero-fill, count 5; link would otherwise be 1
    cycle(mk(0, 1, 0, 2'b00, 5'd5, 1, 0, 0, 1, e_idle(0)), "reset_mid", 0);
    cycle(mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 1, e_left(1, 0, 1)), "reset_mid", 1);
    cycle(mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 1, e_left(1, 0, 1)), "reset_mid", 2);
    cycle(mk(1, 0, 0, 2'b00, 5'd0, 0, 0, 0, 1, e_left(1, 0, 1)), "reset_mid", 3);
    for (int k = 0; k < 6; k++) begin
      cycle(mk(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 1, e_idle(0)), "reset_idle", k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
